// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads instr_memory, assembles 1/2-word instructions.
// Optional PC_BOUND_CHECK_EN adds fetch_fault and halts on out-of-range reads.
module instr_fetch #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 31,
    parameter int RESET_PC  = 0
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        opcode,
    output logic [7:0]        operand,
    output logic              has_operand,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              halted
`ifdef PC_BOUND_CHECK_EN
    ,
    output logic              fetch_fault
`endif
);

    localparam logic [7:0] OP_LOADIM = 8'd33;
    localparam logic [7:0] OP_JUMPZ  = 8'd35;
    localparam logic [7:0] OP_JUMPNZ = 8'd39;
    localparam logic [7:0] OP_JUMP   = 8'd40;
    localparam logic [7:0] OP_ENDOP  = 8'd42;

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_FETCH,
        S_OPC,
        S_ARG,
        S_HOLD,
        S_HALT
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic [7:0]        opcode_q;
    logic [7:0]        operand_q;
    logic              valid_q;
    logic              has_op_q;
    logic              halted_q;

    logic [7:0]        mem_op;
    logic              two_word_d;
    logic              unused_bits;

    assign mem_op = imem_data[7:0];
    assign unused_bits = ^{imem_data[DATA_W-1:8], MEM_DEPTH[0]};

    always_comb begin
        two_word_d = (mem_op == OP_LOADIM) || (mem_op == OP_JUMPZ) ||
                     (mem_op == OP_JUMPNZ) || (mem_op == OP_JUMP);
    end

`ifdef PC_BOUND_CHECK_EN
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);

    logic fault_q;
    logic pc_oob;
    logic tgt_oob;

    assign pc_oob  = {1'b0, pc_q} >= DEPTH_L;
    assign tgt_oob = {1'b0, branch_target} >= DEPTH_L;
    assign fetch_fault = fault_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc_q       <= RST_PC;
            instr_pc_q <= RST_PC;
            opcode_q   <= 8'd0;
            operand_q  <= 8'd0;
            valid_q    <= 1'b0;
            has_op_q   <= 1'b0;
            halted_q   <= 1'b0;
`ifdef PC_BOUND_CHECK_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_FETCH: begin
`ifdef PC_BOUND_CHECK_EN
                    if (pc_oob) begin
                        fault_q  <= 1'b1;
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else
`endif
                    begin
                        pc_q    <= pc_q + PC_ONE;
                        state_q <= S_OPC;
                    end
                end
                // imem_data now holds the word at the address issued in FETCH
                S_OPC: begin
                    opcode_q   <= mem_op;
                    instr_pc_q <= pc_q - PC_ONE;
                    has_op_q   <= two_word_d;
                    if (two_word_d) begin
`ifdef PC_BOUND_CHECK_EN
                        if (pc_oob) begin
                            fault_q  <= 1'b1;
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end else
`endif
                        begin
                            pc_q    <= pc_q + PC_ONE;
                            state_q <= S_ARG;
                        end
                    end else begin
                        operand_q <= 8'd0;
                        valid_q   <= 1'b1;
                        state_q   <= S_HOLD;
                    end
                end
                S_ARG: begin
                    operand_q <= mem_op;
                    valid_q   <= 1'b1;
                    state_q   <= S_HOLD;
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        valid_q <= 1'b0;
                        if (branch_taken) begin
                            pc_q <= branch_target;
                        end
`ifdef PC_BOUND_CHECK_EN
                        if (branch_taken && tgt_oob) begin
                            fault_q  <= 1'b1;
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end else
`endif
                        if (opcode_q == OP_ENDOP) begin
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_HALT: begin
                    halted_q <= 1'b1;
                end
            endcase
        end
    end

    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign opcode      = opcode_q;
    assign operand     = operand_q;
    assign has_operand = has_op_q;
    assign instr_pc    = instr_pc_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random programs checked
// against a transaction-timing model of the fetch stage.
module tb_instr_fetch;

    localparam int DEPTH = 31;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [7:0]  opcode;
    logic [7:0]  operand;
    logic        has_operand;
    logic [15:0] instr_pc;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'd0;
    logic        halted;
`ifdef PC_BOUND_CHECK_EN
    logic        fetch_fault;
`endif

    instr_fetch #(
        .ADDR_W(16), .DATA_W(16), .MEM_DEPTH(DEPTH), .RESET_PC(0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .opcode(opcode),
        .operand(operand),
        .has_operand(has_operand),
        .instr_pc(instr_pc),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .halted(halted)
`ifdef PC_BOUND_CHECK_EN
        ,
        .fetch_fault(fetch_fault)
`endif
    );

    always #5 clock = ~clock;

    logic [15:0] mem [0:255];
    always @(posedge clock) imem_data <= mem[imem_addr[7:0]];

    int checks = 0;
    int errors = 0;
    int n = 0;

    // model: PC of current instruction, cycle its fetch began, halt/fault flags
    logic [15:0] m_pc = 16'd0;
    int          m_start = 0;
    bit          m_halted = 1'b0;
    bit          m_fault = 1'b0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, n);
        end
    endtask

    function automatic bit is2(input logic [7:0] op);
        return op == 8'd33 || op == 8'd35 || op == 8'd39 || op == 8'd40;
    endfunction

    function automatic logic [7:0] byte_at(input logic [15:0] a);
        logic [15:0] w;
        w = mem[a[7:0]];
        return w[7:0];
    endfunction

    function automatic int m_len();
        return is2(byte_at(m_pc)) ? 2 : 1;
    endfunction

    function automatic int fault_d();
`ifdef PC_BOUND_CHECK_EN
        if (int'(m_pc) >= DEPTH) return 1;
        if (is2(byte_at(m_pc)) && int'(m_pc) + 1 >= DEPTH) return 2;
`endif
        return 1 << 30;
    endfunction

    function automatic bit e_fault();
        return m_fault || (!m_halted && (n - m_start) >= fault_d());
    endfunction

    function automatic bit e_halted();
        return m_halted || e_fault();
    endfunction

    function automatic bit e_valid();
        return !e_halted() && (n - m_start) >= m_len() + 1;
    endfunction

    function automatic logic [15:0] e_addr();
        int steps;
        int d;
        if (m_halted) return m_pc;
        d = n - m_start;
        steps = (fault_d() == 1) ? 0 : (fault_d() == 2) ? 1 : m_len();
        if (d < steps) steps = d;
        return m_pc + 16'(steps);
    endfunction

    function automatic logic [7:0] e_operand();
        return is2(byte_at(m_pc)) ? byte_at(m_pc + 16'd1) : 8'd0;
    endfunction

    task automatic compare();
        chk("instr_valid", instr_valid, e_valid());
        chk("halted", halted, e_halted());
        chk("imem_addr", imem_addr, e_addr());
`ifdef PC_BOUND_CHECK_EN
        chk("fetch_fault", fetch_fault, e_fault());
`endif
        if (e_valid()) begin
            chk("opcode", opcode, byte_at(m_pc));
            chk("operand", operand, e_operand());
            chk("has_operand", has_operand, is2(byte_at(m_pc)));
            chk("instr_pc", instr_pc, m_pc);
        end
    endtask

    task automatic tick(input bit r, input bit b, input logic [15:0] t);
        logic [15:0] np;
        instr_ready = r;
        branch_taken = b;
        branch_target = t;
        if (e_valid() && r) begin
            np = b ? t : m_pc + 16'(m_len());
`ifdef PC_BOUND_CHECK_EN
            if (b && int'(t) >= DEPTH) begin
                m_halted = 1'b1;
                m_fault = 1'b1;
            end else
`endif
            if (byte_at(m_pc) == 8'd42) m_halted = 1'b1;
            m_pc = np;
            m_start = n + 1;
        end
        @(negedge clock);
        n++;
        compare();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        instr_ready = 1'($urandom);
        branch_taken = 1'b0;
        @(negedge clock);
        n++;
        m_pc = 16'd0;
        m_start = n;
        m_halted = 1'b0;
        m_fault = 1'b0;
        chk("rst_valid", instr_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_operand", operand, 0);
        chk("rst_has_operand", has_operand, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_imem_addr", imem_addr, 0);
        compare();
        reset = 1'b0;
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!instr_valid && k < 20) begin
            tick(1'b0, 1'b0, 16'd0);
            k++;
        end
        chk("wait_valid", instr_valid, 1);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = {8'($urandom), 8'd0};
    endtask

    initial begin
        int k;
        logic [7:0] b;

        // LOADIM 5 then a 1-word opcode 5
        clear_mem();
        mem[0] = 16'hA521; mem[1] = 16'h3C05; mem[2] = 16'h0005;
        do_reset();
        wait_valid(k);
        chk("t1_latency", k, 3);
        chk("t1_opcode", opcode, 33);
        chk("t1_operand", operand, 5);
        chk("t1_has_operand", has_operand, 1);
        chk("t1_instr_pc", instr_pc, 0);
        tick(1'b1, 1'b0, 16'd0);
        wait_valid(k);
        chk("t1b_latency", k, 2);
        chk("t1b_opcode", opcode, 5);
        chk("t1b_operand", operand, 0);
        chk("t1b_instr_pc", instr_pc, 2);

        // backpressure holds the instruction
        do_reset();
        wait_valid(k);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'($urandom), 16'd9);
            chk("t2_addr_hold", imem_addr, 2);
            chk("t2_opcode_hold", opcode, 33);
            chk("t2_operand_hold", operand, 5);
        end
        tick(1'b1, 1'b0, 16'd0);
        chk("t2_valid_drop", instr_valid, 0);
        wait_valid(k);
        chk("t2_next_pc", instr_pc, 2);

        // taken jump
        clear_mem();
        mem[0] = 16'd40; mem[1] = 16'd7; mem[7] = 16'd41;
        do_reset();
        wait_valid(k);
        tick(1'b1, 1'b1, 16'd7);
        wait_valid(k);
        chk("t3_instr_pc", instr_pc, 7);
        chk("t3_opcode", opcode, 41);

        // ENDOP halts until reset
        clear_mem();
        mem[0] = 16'd42;
        do_reset();
        wait_valid(k);
        tick(1'b1, 1'b0, 16'd0);
        chk("t4_halted", halted, 1);
        for (int i = 0; i < 12; i++) tick(1'($urandom), 1'($urandom), 16'd3);
        chk("t4_still_invalid", instr_valid, 0);
        do_reset();
        chk("t4_pc_after_reset", imem_addr, 0);

        // reset in the middle of a LOADIM (ARG state)
        clear_mem();
        mem[0] = 16'd33; mem[1] = 16'd9;
        do_reset();
        tick(1'b0, 1'b0, 16'd0);
        tick(1'b0, 1'b0, 16'd0);
        do_reset();
        wait_valid(k);
        chk("t5_opcode", opcode, 33);
        chk("t5_operand", operand, 9);
        chk("t5_instr_pc", instr_pc, 0);

`ifdef PC_BOUND_CHECK_EN
        clear_mem();
        mem[0] = 16'd40; mem[1] = 16'd7;
        do_reset();
        wait_valid(k);
        tick(1'b1, 1'b1, 16'd31);
        chk("t6_fault", fetch_fault, 1);
        chk("t6_halted", halted, 1);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 16'd0);
        chk("t6_no_valid", instr_valid, 0);
`endif

        // random programs
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 256; i++) begin
                case ($urandom_range(0, 19))
                    0:       b = 8'd42;
                    1, 2:    b = 8'd33;
                    3:       b = 8'd35;
                    4:       b = 8'd39;
                    5:       b = 8'd40;
                    default: b = 8'($urandom);
                endcase
                mem[i] = {8'($urandom), b};
            end
            do_reset();
            for (int c = 0; c < 300; c++) begin
                if ($urandom_range(0, 149) == 0) do_reset();
                else tick($urandom_range(0, 3) != 0,
                          $urandom_range(0, 3) == 0,
                          16'($urandom_range(0, 34)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
